// File: rtl/vga_sync_generator.sv
// vga_sync_generator: parametrised VGA raster timing generator.
// A clock divider produces one pixel advance every DIV clocks; the horizontal
// and vertical counters, sync outputs and video_on are all registered from the
// next-counter values so they move together on the advancing edge.
// Optional feature macro: VGA_FRAME_COUNTER_EN (enables the 8-bit frame_cnt).
module vga_sync_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int DIV      = 2,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cntHorizontal,
  output logic [CNT_W-1:0] cntVertical,
  output logic             HSync,
  output logic             VSync,
  output logic             video_on,
  output logic             pixel_tick,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS        = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS        = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO     = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE      = DIV_W'(1);
  localparam logic             H_ACT_LVL    = (H_POL != 0) ? 1'b1 : 1'b0;
  localparam logic             V_ACT_LVL    = (V_POL != 0) ? 1'b1 : 1'b0;

  logic [DIV_W-1:0] divCnt_r;
  logic [DIV_W-1:0] divNext_s;
  logic             advance_s;
  logic [CNT_W-1:0] hCnt_r;
  logic [CNT_W-1:0] vCnt_r;
  logic [CNT_W-1:0] hNext_s;
  logic [CNT_W-1:0] vNext_s;
  logic             hSyncNext_s;
  logic             vSyncNext_s;
  logic             videoOnNext_s;
  logic             frameStartNext_s;
  logic             hSync_r;
  logic             vSync_r;
  logic             videoOn_r;
  logic             pixelTick_r;
  logic             frameStart_r;

  // Pixel divider and raster counter next-state (h wraps into a v increment)
  always_comb begin
    divNext_s = divCnt_r;
    hNext_s   = hCnt_r;
    vNext_s   = vCnt_r;
    advance_s = (divCnt_r == DIV_LAST);
    if (advance_s) begin
      divNext_s = DIV_ZERO;
      if (hCnt_r == H_LAST) begin
        hNext_s = CNT_ZERO;
        if (vCnt_r == V_LAST) begin
          vNext_s = CNT_ZERO;
        end else begin
          vNext_s = vCnt_r + CNT_ONE;
        end
      end else begin
        hNext_s = hCnt_r + CNT_ONE;
        vNext_s = vCnt_r;
      end
    end else begin
      divNext_s = divCnt_r + DIV_ONE;
    end
  end

  // Decode syncs, visible area and frame start from the next counter values
  always_comb begin
    hSyncNext_s      = ~H_ACT_LVL;
    vSyncNext_s      = ~V_ACT_LVL;
    videoOnNext_s    = 1'b0;
    frameStartNext_s = 1'b0;
    if ((hNext_s >= H_SYNC_START) && (hNext_s < H_SYNC_END)) begin
      hSyncNext_s = H_ACT_LVL;
    end else begin
      hSyncNext_s = ~H_ACT_LVL;
    end
    if ((vNext_s >= V_SYNC_START) && (vNext_s < V_SYNC_END)) begin
      vSyncNext_s = V_ACT_LVL;
    end else begin
      vSyncNext_s = ~V_ACT_LVL;
    end
    if ((hNext_s < H_VIS) && (vNext_s < V_VIS)) begin
      videoOnNext_s = 1'b1;
    end else begin
      videoOnNext_s = 1'b0;
    end
    if (advance_s && (hNext_s == CNT_ZERO) && (vNext_s == CNT_ZERO)) begin
      frameStartNext_s = 1'b1;
    end else begin
      frameStartNext_s = 1'b0;
    end
  end

  // Timing state: reset parks the raster on the last position so the first
  // advance lands on (0,0)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt_r     <= DIV_ZERO;
      hCnt_r       <= H_LAST;
      vCnt_r       <= V_LAST;
      hSync_r      <= ~H_ACT_LVL;
      vSync_r      <= ~V_ACT_LVL;
      videoOn_r    <= 1'b0;
      pixelTick_r  <= 1'b0;
      frameStart_r <= 1'b0;
    end else begin
      divCnt_r     <= divNext_s;
      hCnt_r       <= hNext_s;
      vCnt_r       <= vNext_s;
      hSync_r      <= hSyncNext_s;
      vSync_r      <= vSyncNext_s;
      videoOn_r    <= videoOnNext_s;
      pixelTick_r  <= advance_s;
      frameStart_r <= frameStartNext_s;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [7:0] frameCnt_r;

  // Frame counter steps on the edge that raises frame_start, wrapping at 255
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frameCnt_r <= 8'd0;
    end else if (frameStartNext_s) begin
      frameCnt_r <= frameCnt_r + 8'd1;
    end else begin
      frameCnt_r <= frameCnt_r;
    end
  end

  assign frame_cnt = frameCnt_r;
`else
  assign frame_cnt = 8'd0;
`endif

  assign cntHorizontal = hCnt_r;
  assign cntVertical   = vCnt_r;
  assign HSync         = hSync_r;
  assign VSync         = vSync_r;
  assign video_on      = videoOn_r;
  assign pixel_tick    = pixelTick_r;
  assign frame_start   = frameStart_r;

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

Parametrised VGA raster timing generator: free-running horizontal and vertical pixel counters, HSync/VSync with configurable porch/sync widths and polarity, active-video flag, pixel-rate tick and frame-start pulse. Supersedes the fixed-range combinational HSync decoder. It sits between the board clock and the pixel/colour path, and its counters address the frame/character memory.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: HSync pulse width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: VSync pulse width, in lines
- V_BP, 33: vertical back porch, in lines
- H_POL, 0: HSync active level (0 = active-low, 1 = active-high)
- V_POL, 0: VSync active level
- DIV, 2: clk cycles per pixel (≥1)
- CNT_W, 11: counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cntHorizontal  out  CNT_W  current pixel column
- cntVertical  out  CNT_W  current line
- HSync  out  1  horizontal sync
- VSync  out  1  vertical sync
- video_on  out  1  high while the current pixel is in the visible area
- pixel_tick  out  1  one-clk pulse marking a new pixel position
- frame_start  out  1  one-clk pulse at pixel (0,0)
- frame_cnt  out  8  frame counter (see Configuration)

Clock and reset: one clock; reset is asynchronous and active-high.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way from the vertical parameters. Defaults give 800 × 525.
- Divider counts 0..DIV-1 on every clk. An internal advance occurs on the edge where the divider equals DIV-1, and the divider then wraps to 0.
- On each advance, cntHorizontal increments. If cntHorizontal = H_TOTAL-1, it wraps to 0 and cntVertical increments; cntVertical wraps from V_TOTAL-1 to 0.
- HSync and VSync are registered and decoded from the next counter values, so they change on the same edge as the counters.
- HSync is at its active level iff H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC; otherwise it is at the inactive level.
- VSync follows the same rule with the vertical parameters.
- video_on is registered and aligned in the same way. It is 1 iff h < H_ACTIVE and v < V_ACTIVE.
- pixel_tick is 1 for exactly the clk cycle following each advance. With DIV=1 it is constantly 1 after reset.
- frame_start is 1 in the pixel_tick cycle whose counters are (0,0), and 0 otherwise.
- Arithmetic is unsigned. All comparisons are done at CNT_W bits.

## Timing
- Reset values:
  - cntHorizontal = H_TOTAL-1, cntVertical = V_TOTAL-1.
  - HSync = !H_POL, VSync = !V_POL (inactive level).
  - video_on = 0, pixel_tick = 0, frame_start = 0, frame_cnt = 0, divider = 0.
- First advance after reset release happens at rising edge number DIV. Counters go to (0,0), and frame_start/pixel_tick are high in the following cycle.
- Latency from an advance to the matching sync/video_on change is 0 cycles (same edge).
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronous) and hold while reset is high. After release, operation restarts exactly as from power-up.
- Wrap-around: h and v both wrap on the same advance at (H_TOTAL-1, V_TOTAL-1). That advance produces frame_start.

## Configuration
- VGA_FRAME_COUNTER_EN defined:
  - frame_cnt increments by 1 in the cycle frame_start is high, wrapping 255→0.
  - Reset value is 0.
- Not defined:
  - frame_cnt is constant 0 and no counter register is synthesised.

## Test plan
1. Defaults, release reset → at clk edge 2 the counters are (0,0), then frame_start=1, pixel_tick=1, video_on=1, HSync=1, VSync=1.
2. Advance h 655→656 → HSync falls to 0. It returns to 1 at h=752, which is 96 pixel ticks (192 clks) later.
3. h 639→640 → video_on=0 until h wraps 799→0. On that wrap cntVertical increments by 1 and video_on returns to 1.
4. v 489→490 → VSync=0 for 1600 pixel ticks and rises at v=492. At v=480 video_on stays 0 for all pixels until v wraps 524→0.
5. Run 2 frames → frame_start period is exactly 840000 clks.
   - With VGA_FRAME_COUNTER_EN, frame_cnt reads 1 then 2.
   - Without it, frame_cnt stays 0.
   - With DIV=1, H_POL=1, the period is 420000 clks and HSync idles at 0.
6. Assert reset at h=300, v=100 between clk edges → outputs go immediately to 799/524, inactive syncs and video_on=0. After release the sequence matches scenario 1.
